// File: rtl/priority_encoder_iter.sv
// priority_encoder_iter: sequential priority encoder.
// Accepts an N-bit request vector over a valid/ready handshake. It then emits
// the index of every set bit, highest priority first, one index per output
// handshake.
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake; in_vec is the N-bit request vector
//   out_valid/out_ready output handshake; out_idx is the current index,
//                     out_last marks the final set bit of the vector
//   zero_pulse        one-cycle pulse after an all-zero vector is accepted
//   busy              a vector is being iterated
// Optional: define PRIORITY_ENCODER_ITER_PRELOAD_EN to let a new vector load
// on the same edge as the last-beat handshake (no bubble between vectors).
module priority_encoder_iter #(
  parameter int N        = 8,
  parameter int HI_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 zero_pulse,
  output logic                 busy
);

  localparam int W = $clog2(N);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   pending, pending_nx;
  logic           zero_q, zero_nx;
  logic [W-1:0]   idx;
  logic           single;
  logic           scan;

  assign scan = (state == SCAN);

  // The last match in loop order wins. Ascending order therefore selects the
  // highest set bit, and descending order selects the lowest set bit.
  always_comb begin
    idx = '0;
    if (HI_FIRST != 0) begin
      for (int unsigned i = 0; i < N; i++)
        if (pending[i]) idx = W'(i);
    end else begin
      for (int unsigned i = N; i > 0; i--)
        if (pending[i-1]) idx = W'(i - 1);
    end
  end

  // Exactly one bit is set. SCAN always holds a nonzero pending vector.
  assign single = ((pending & (pending - N'(1))) == '0) && (pending != '0);

  assign out_valid  = scan;
  assign busy       = scan;
  assign out_idx    = scan ? idx : '0;
  assign out_last   = scan && single;
  assign zero_pulse = zero_q;

`ifdef PRIORITY_ENCODER_ITER_PRELOAD_EN
  assign in_ready = !rst && (!scan || (single && out_ready));
`else
  assign in_ready = !rst && !scan;
`endif

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    zero_nx    = 1'b0;
    if (!scan) begin
      if (in_valid && in_ready) begin
        if (in_vec != '0) begin
          pending_nx = in_vec;
          state_nx   = SCAN;
        end else begin
          zero_nx = 1'b1;
        end
      end
    end else if (out_ready) begin
      pending_nx = pending & ~(N'(1) << idx);
      if (single) state_nx = IDLE;
`ifdef PRIORITY_ENCODER_ITER_PRELOAD_EN
      // in_ready in SCAN implies this is the last-beat handshake.
      if (in_valid && in_ready) begin
        if (in_vec != '0) begin
          pending_nx = in_vec;
          state_nx   = SCAN;
        end else begin
          zero_nx = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      zero_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      zero_q  <= zero_nx;
    end
  end

endmodule

// File: tb/tb_priority_encoder_iter.sv
module tb_priority_encoder_iter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       out_ready;

  logic       h_in_ready, h_out_valid, h_out_last, h_zero, h_busy;
  logic [2:0] h_idx;
  logic       l_in_ready, l_out_valid, l_out_last, l_zero, l_busy;
  logic [2:0] l_idx;

  int tests  = 0;
  int failed = 0;

  priority_encoder_iter #(.N(8), .HI_FIRST(1)) u_hi (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_vec(in_vec), .out_valid(h_out_valid), .out_ready(out_ready),
    .out_idx(h_idx), .out_last(h_out_last), .zero_pulse(h_zero), .busy(h_busy)
  );

  priority_encoder_iter #(.N(8), .HI_FIRST(0)) u_lo (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_vec(in_vec), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_idx(l_idx), .out_last(l_out_last), .zero_pulse(l_zero), .busy(l_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic last);
    chk({tag, "_valid"}, 32'(h_out_valid), 32'd1);
    chk({tag, "_idx"},   32'(h_idx),       32'(idx));
    chk({tag, "_last"},  32'(h_out_last),  32'(last));
  endtask

  initial begin
    int hi_exp [4];
    int lo_exp [4];
    hi_exp = '{7, 5, 2, 0};
    lo_exp = '{0, 2, 5, 7};

    rst = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready",  32'(h_in_ready),  32'd0);
    chk("rst_out_valid", 32'(h_out_valid), 32'd0);
    chk("rst_idx",       32'(h_idx),       32'd0);
    chk("rst_last",      32'(h_out_last),  32'd0);
    chk("rst_zero",      32'(h_zero),      32'd0);
    chk("rst_busy",      32'(h_busy),      32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(h_in_ready), 32'd1);

    // 8'hA5: MSB-first on u_hi, LSB-first on u_lo
    in_valid = 1'b1; in_vec = 8'hA5;
    tick();
    in_valid = 1'b0; in_vec = 8'h00;
    chk("a5_busy",     32'(h_busy),     32'd1);
    chk("a5_in_ready", 32'(h_in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk_beat("a5_hi", hi_exp[i], (i == 3));
      chk("a5_lo_valid", 32'(l_out_valid), 32'd1);
      chk("a5_lo_idx",   32'(l_idx),       32'(lo_exp[i]));
      chk("a5_lo_last",  32'(l_out_last),  32'(i == 3));
      tick();
    end
    chk("a5_done_valid",    32'(h_out_valid), 32'd0);
    chk("a5_done_in_ready", 32'(h_in_ready),  32'd1);
    chk("a5_done_busy",     32'(h_busy),      32'd0);
    chk("a5_lo_done_valid", 32'(l_out_valid), 32'd0);

    // Zero vector
    in_valid = 1'b1; in_vec = 8'h00;
    tick();
    in_valid = 1'b0;
    chk("zero_pulse",    32'(h_zero),      32'd1);
    chk("zero_valid",    32'(h_out_valid), 32'd0);
    chk("zero_in_ready", 32'(h_in_ready),  32'd1);
    tick();
    chk("zero_pulse_off", 32'(h_zero),      32'd0);
    chk("zero_valid2",    32'(h_out_valid), 32'd0);

    // Stall: 8'h81 with out_ready low for 3 cycles; a vector offered during
    // the stall must be ignored
    in_valid = 1'b1; in_vec = 8'h81; out_ready = 1'b0;
    tick();
    in_vec = 8'h10;
    for (int i = 0; i < 3; i++) begin
      chk_beat("stall", 7, 1'b0);
      chk("stall_in_ready", 32'(h_in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0; in_vec = 8'h00;
    chk_beat("stall_rel", 7, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_beat("stall_last", 0, 1'b1);
    tick();
    chk("stall_done_valid", 32'(h_out_valid), 32'd0);
    tick();
    chk("stall_no_latch", 32'(h_out_valid), 32'd0);

    // Reset mid-scan
    in_valid = 1'b1; in_vec = 8'hFF;
    tick();
    in_valid = 1'b0; in_vec = 8'h00;
    chk_beat("rs_b0", 7, 1'b0); tick();
    chk_beat("rs_b1", 6, 1'b0); tick();
    chk_beat("rs_b2", 5, 1'b0); tick();
    chk_beat("rs_b3", 4, 1'b0);
    rst = 1'b1;
    tick();
    chk("rs_valid",    32'(h_out_valid), 32'd0);
    chk("rs_busy",     32'(h_busy),      32'd0);
    chk("rs_idx",      32'(h_idx),       32'd0);
    chk("rs_in_ready", 32'(h_in_ready),  32'd0);
    rst = 1'b0;
    #1;
    chk("rs_in_ready_after", 32'(h_in_ready), 32'd1);
    tick();
    chk("rs_no_beats", 32'(h_out_valid), 32'd0);

    // Back-to-back 8'h02 then 8'h40
    in_valid = 1'b1; in_vec = 8'h02;
    tick();
    in_vec = 8'h40;
    chk_beat("b2b_first", 1, 1'b1);
`ifdef PRIORITY_ENCODER_ITER_PRELOAD_EN
    chk("b2b_in_ready", 32'(h_in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_vec = 8'h00;
`else
    chk("b2b_in_ready", 32'(h_in_ready), 32'd0);
    tick();
    chk("b2b_bubble_valid", 32'(h_out_valid), 32'd0);
    chk("b2b_bubble_ready", 32'(h_in_ready),  32'd1);
    tick();
    in_valid = 1'b0; in_vec = 8'h00;
`endif
    chk_beat("b2b_second", 6, 1'b1);
    tick();
    chk("b2b_done_valid", 32'(h_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
